// File: rtl/async_sram_ctrl_pkg.sv
// Shared definitions for the async SRAM controller and its PHY: state encoding,
// default bus widths and the legal read wait-state range.
package async_sram_ctrl_pkg;

    localparam int W_ADDR_DFLT     = 18;
    localparam int W_DATA_DFLT     = 16;
    localparam int READ_CYCLES_MIN = 1;
    localparam int READ_CYCLES_MAX = 15;
    localparam int W_CNT           = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD        = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_WR_HOLD   = 3'd4
    } state_e;

    function automatic bit read_cycles_ok(input int rc);
        return (rc >= READ_CYCLES_MIN) && (rc <= READ_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/async_sram_ctrl_if.sv
// Word request/response channel between a single requester and the SRAM controller.
interface async_sram_ctrl_if #(
    parameter int W_ADDR = async_sram_ctrl_pkg::W_ADDR_DFLT,
    parameter int W_DATA = async_sram_ctrl_pkg::W_DATA_DFLT
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [W_ADDR-1:0]     req_addr;
    logic [W_DATA-1:0]     req_wdata;
    logic [W_DATA/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic [W_DATA-1:0]     resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/async_sram_ctrl.sv
// Sequences word reads/writes into registered ctrl_* strobes for the async SRAM PHY,
// owning read wait-states, the write strobe and DQ turnaround.
module async_sram_ctrl
    import async_sram_ctrl_pkg::*;
#(
    parameter int W_ADDR      = W_ADDR_DFLT,
    parameter int W_DATA      = W_DATA_DFLT,
    parameter int READ_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    async_sram_ctrl_if.slave    bus,
    output logic [W_ADDR-1:0]   ctrl_addr,
    output logic [W_DATA-1:0]   ctrl_dq_out,
    output logic [W_DATA-1:0]   ctrl_dq_oe,
    input  logic [W_DATA-1:0]   ctrl_dq_in,
    output logic                ctrl_ce_n,
    output logic                ctrl_we_n,
    output logic                ctrl_oe_n,
    output logic [W_DATA/8-1:0] ctrl_byte_n
);

    localparam int W_BE = W_DATA / 8;

    if (!read_cycles_ok(READ_CYCLES)) begin : g_bad_read_cycles
        $error("async_sram_ctrl: READ_CYCLES=%0d outside %0d..%0d",
               READ_CYCLES, READ_CYCLES_MIN, READ_CYCLES_MAX);
    end
    if ((W_DATA % 8) != 0 || W_DATA == 0) begin : g_bad_w_data
        $error("async_sram_ctrl: W_DATA=%0d is not a multiple of 8", W_DATA);
    end

    state_e            state, state_nxt;
    logic [W_CNT-1:0]  cnt, cnt_nxt;
    logic [W_ADDR-1:0] addr_nxt;
    logic [W_DATA-1:0] dq_out_nxt;
    logic [W_BE-1:0]   byte_n_nxt;
    logic              ce_n_nxt, we_n_nxt, oe_n_nxt;
    logic              dq_oe_q, dq_oe_nxt;
    logic              resp_valid_q, resp_valid_nxt;
    logic [W_DATA-1:0] resp_rdata_q, resp_rdata_nxt;

    // A single enable bit fans out to every lane, so the lanes can never disagree.
    assign ctrl_dq_oe     = {W_DATA{dq_oe_q}};
    assign bus.req_ready  = (state == ST_IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        addr_nxt       = ctrl_addr;
        dq_out_nxt     = ctrl_dq_out;
        byte_n_nxt     = ctrl_byte_n;
        ce_n_nxt       = 1'b1;
        we_n_nxt       = 1'b1;
        oe_n_nxt       = 1'b1;
        dq_oe_nxt      = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata_q;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_nxt = bus.req_addr;
                    ce_n_nxt = 1'b0;
                    if (bus.req_write) begin
                        state_nxt  = ST_WR_SETUP;
                        byte_n_nxt = ~bus.req_wmask;
                        dq_out_nxt = bus.req_wdata;
                    end else begin
                        state_nxt  = ST_RD;
                        byte_n_nxt = '0;
                        oe_n_nxt   = 1'b0;
                        cnt_nxt    = W_CNT'(READ_CYCLES);
                    end
                end
            end
            ST_RD: begin
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                if (cnt == '0) begin
                    // CE/OE linger through the following IDLE cycle so a
                    // back-to-back read keeps OE asserted without a gap.
                    state_nxt      = ST_IDLE;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = ctrl_dq_in;
                end else begin
                    cnt_nxt = cnt - W_CNT'(1);
                end
            end
            ST_WR_SETUP: begin
                state_nxt = ST_WR_STROBE;
                ce_n_nxt  = 1'b0;
                we_n_nxt  = 1'b0;
                dq_oe_nxt = 1'b1;
            end
            ST_WR_STROBE: begin
                state_nxt = ST_WR_HOLD;
                ce_n_nxt  = 1'b0;
                dq_oe_nxt = 1'b1;
            end
            ST_WR_HOLD: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ctrl_addr    <= '0;
            ctrl_dq_out  <= '0;
            ctrl_byte_n  <= '1;
            ctrl_ce_n    <= 1'b1;
            ctrl_we_n    <= 1'b1;
            ctrl_oe_n    <= 1'b1;
            dq_oe_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            ctrl_addr    <= addr_nxt;
            ctrl_dq_out  <= dq_out_nxt;
            ctrl_byte_n  <= byte_n_nxt;
            ctrl_ce_n    <= ce_n_nxt;
            ctrl_we_n    <= we_n_nxt;
            ctrl_oe_n    <= oe_n_nxt;
            dq_oe_q      <= dq_oe_nxt;
            resp_valid_q <= resp_valid_nxt;
            resp_rdata_q <= resp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Randomised bench for async_sram_ctrl: pin-level SRAM model plus a transaction-level
// reference memory, with turnaround and timing monitors.
module tb_async_sram_ctrl;
    import async_sram_ctrl_pkg::*;

    localparam int W_ADDR = 18;
    localparam int W_DATA = 16;
    localparam int W_BE   = 2;
    localparam int RC     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    async_sram_ctrl_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

    logic [W_ADDR-1:0] ctrl_addr;
    logic [W_DATA-1:0] ctrl_dq_out, ctrl_dq_oe;
    logic [W_DATA-1:0] ctrl_dq_in = '0;
    logic              ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
    logic [W_BE-1:0]   ctrl_byte_n;

    async_sram_ctrl #(.W_ADDR(W_ADDR), .W_DATA(W_DATA), .READ_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ctrl_addr(ctrl_addr), .ctrl_dq_out(ctrl_dq_out), .ctrl_dq_oe(ctrl_dq_oe),
        .ctrl_dq_in(ctrl_dq_in), .ctrl_ce_n(ctrl_ce_n), .ctrl_we_n(ctrl_we_n),
        .ctrl_oe_n(ctrl_oe_n), .ctrl_byte_n(ctrl_byte_n)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory contents default to an address-derived pattern until written.
    logic [15:0] sram_mem [int];
    logic [15:0] ref_mem  [int];

    function automatic logic [15:0] dflt(input int a);
        return 16'(a) ^ 16'hc3a5;
    endfunction
    function automatic logic [15:0] sram_get(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
    endfunction
    function automatic logic [15:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    typedef struct {
        int          acc_edge;
        logic [15:0] data;
    } rd_exp_t;
    rd_exp_t exp_q [$];

    bit          wp_vld = 0;
    int          wp_edge, wp_addr;
    logic [15:0] wp_data;
    logic [1:0]  wp_mask;

    int   cyc = 0;
    int   viol = 0;
    int   last_dqoe = -100;
    int   oe_hi_b2b = 0;
    int   resp_cnt = 0;
    bit   b2b_win = 0;
    logic prev_we_n = 1'b1;
    logic prev_oe_n = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Everything observable is sampled on the falling edge.
    initial forever begin
        rd_exp_t     e;
        logic [15:0] v;
        int          a;
        @(negedge clk);

        if (ctrl_dq_oe !== '0 && ctrl_dq_oe !== '1) viol++;
        if (ctrl_dq_oe !== '0 && ctrl_oe_n === 1'b0) viol++;
        if (ctrl_we_n === 1'b0 && (ctrl_dq_oe !== '1 || ctrl_ce_n !== 1'b0)) viol++;
        if (prev_oe_n === 1'b1 && ctrl_oe_n === 1'b0 && (cyc - last_dqoe) < 2) viol++;
        if (ctrl_dq_oe !== '0) last_dqoe = cyc;
        if (b2b_win && ctrl_oe_n !== 1'b0) oe_hi_b2b++;

        // A write lands on the rising edge of WE only if CE and the data are still held.
        if (prev_we_n === 1'b0 && ctrl_we_n === 1'b1 && ctrl_ce_n === 1'b0 && ctrl_dq_oe === '1) begin
            a = int'(ctrl_addr);
            v = sram_get(a);
            for (int b = 0; b < W_BE; b++)
                if (!ctrl_byte_n[b]) v[b*8 +: 8] = ctrl_dq_out[b*8 +: 8];
            sram_mem[a] = v;
        end
        prev_we_n = ctrl_we_n;
        prev_oe_n = ctrl_oe_n;

        if (bus.resp_valid === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) chk("resp_unexpected", 32'(1), 32'(0));
            else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(bus.resp_rdata), 32'(e.data));
                chk("rd_latency", 32'(cyc - e.acc_edge), 32'(RC + 1));
            end
        end

        // Reference: a write is done once the strobe edge passed without reset.
        if (wp_vld && cyc >= wp_edge + 2) begin
            v = ref_get(wp_addr);
            for (int b = 0; b < W_BE; b++)
                if (wp_mask[b]) v[b*8 +: 8] = wp_data[b*8 +: 8];
            ref_mem[wp_addr] = v;
            wp_vld = 0;
        end
        if (rst) begin
            exp_q.delete();
            wp_vld = 0;
        end else if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            if (bus.req_write) begin
                wp_vld  = 1;
                wp_edge = cyc + 1;
                wp_addr = int'(bus.req_addr);
                wp_data = bus.req_wdata;
                wp_mask = bus.req_wmask;
            end else begin
                exp_q.push_back('{cyc + 1, ref_get(int'(bus.req_addr))});
            end
        end

        ctrl_dq_in = (ctrl_ce_n === 1'b0 && ctrl_oe_n === 1'b0) ? sram_get(int'(ctrl_addr)) : '0;
    end

    // Drivers are called just after a rising edge and return just after the accept edge.
    task automatic issue(input bit wr, input int addr, input logic [15:0] d, input logic [1:0] m);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = W_ADDR'(addr);
        bus.req_wdata = d;
        bus.req_wmask = m;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !wp_vld) begin
                #1;
                return;
            end
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(bus.req_ready), 32'(0));
        chk({tag, "_ce_n"},   32'(ctrl_ce_n), 32'(1));
        chk({tag, "_we_n"},   32'(ctrl_we_n), 32'(1));
        chk({tag, "_oe_n"},   32'(ctrl_oe_n), 32'(1));
        chk({tag, "_dq_oe"},  32'(ctrl_dq_oe), 32'(0));
        chk({tag, "_byte_n"}, 32'(ctrl_byte_n), 32'(3));
        chk({tag, "_addr"},   32'(ctrl_addr), 32'(0));
        chk({tag, "_dq_out"}, 32'(ctrl_dq_out), 32'(0));
        chk({tag, "_resp_v"}, 32'(bus.resp_valid), 32'(0));
        chk({tag, "_rdata"},  32'(bus.resp_rdata), 32'(0));
    endtask

    initial begin
        logic [15:0] old, w1, w2;
        int          rc0, gap;
        logic [15:0] exp_we [3];
        logic [15:0] exp_oe [3];

        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        sram_mem[32'h12345] = 16'hBEEF;
        ref_mem[32'h12345]  = 16'hBEEF;

        // Reset held with a request pending.
        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("rst");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'(bus.req_ready), 32'(1));
        @(posedge clk);
        #1 idle();
        drain();

        // Single read with wait-states.
        issue(0, 32'h12345, '0, '0);
        idle();
        @(negedge clk);
        chk("rd_oe_n", 32'(ctrl_oe_n), 32'(0));
        chk("rd_addr", 32'(ctrl_addr), 32'h12345);
        chk("rd_byte_n", 32'(ctrl_byte_n), 32'(0));
        @(posedge clk);
        #1 drain();
        @(negedge clk);
        chk("rd_pulse_once", 32'(bus.resp_valid), 32'(0));
        @(posedge clk);
        #1;

        // Upper-byte write: three-cycle strobe sequence.
        old = sram_get(32'h10);
        exp_we = '{16'h1, 16'h0, 16'h1};
        exp_oe = '{16'h0, 16'hffff, 16'hffff};
        issue(1, 32'h10, 16'hA55A, 2'b10);
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bw_we_n",   32'(ctrl_we_n), 32'(exp_we[k]));
            chk("bw_dq_oe",  32'(ctrl_dq_oe), 32'(exp_oe[k]));
            chk("bw_addr",   32'(ctrl_addr), 32'h10);
            chk("bw_dq_out", 32'(ctrl_dq_out), 32'hA55A);
            chk("bw_byte_n", 32'(ctrl_byte_n), 32'(2'b01));
            chk("bw_ce_n",   32'(ctrl_ce_n), 32'(0));
            chk("bw_oe_n",   32'(ctrl_oe_n), 32'(1));
            chk("bw_ready",  32'(bus.req_ready), 32'(0));
        end
        @(negedge clk);
        chk("bw_ready_back", 32'(bus.req_ready), 32'(1));
        chk("bw_mem", 32'(sram_get(32'h10)), 32'({8'hA5, old[7:0]}));
        @(posedge clk);
        #1;

        // Empty byte mask still runs the sequence but changes nothing.
        issue(1, 7, 16'hFFFF, 2'b00);
        idle();
        drain();
        chk("wmask0_mem", 32'(sram_get(7)), 32'(dflt(7)));

        // Write -> read -> write -> read on one address.
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        issue(1, 3, w1, 2'b11);
        idle();
        issue(0, 3, '0, '0);
        idle();
        drain();
        issue(1, 3, w2, 2'b01);
        idle();
        issue(0, 3, '0, '0);
        idle();
        drain();
        chk("wrw_mem", 32'(sram_get(3)), 32'({w1[15:8], w2[7:0]}));

        // Back-to-back reads with valid held.
        issue(0, 0, '0, '0);
        b2b_win = 1;
        rc0 = resp_cnt;
        issue(0, 1, '0, '0);
        issue(0, 2, '0, '0);
        idle();
        drain();
        b2b_win = 0;
        chk("b2b_oe_gap", 32'(oe_hi_b2b), 32'(0));
        chk("b2b_pulses", 32'(resp_cnt - rc0), 32'(3));

        // Reset during RD with one wait-state left.
        issue(0, 5, '0, '0);
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rc0 = resp_cnt;
        @(negedge clk);
        chk("rstrd_ce_n",   32'(ctrl_ce_n), 32'(1));
        chk("rstrd_oe_n",   32'(ctrl_oe_n), 32'(1));
        chk("rstrd_addr",   32'(ctrl_addr), 32'(0));
        chk("rstrd_byte_n", 32'(ctrl_byte_n), 32'(3));
        chk("rstrd_resp_v", 32'(bus.resp_valid), 32'(0));
        chk("rstrd_rdata",  32'(bus.resp_rdata), 32'(0));
        repeat (6) @(negedge clk);
        chk("rstrd_no_pulse", 32'(resp_cnt - rc0), 32'(0));
        @(posedge clk);
        #1;

        // Reset during WR_STROBE.
        issue(1, 32'h20, 16'h1234, 2'b11);
        idle();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstwr_we_n",  32'(ctrl_we_n), 32'(1));
        chk("rstwr_ce_n",  32'(ctrl_ce_n), 32'(1));
        chk("rstwr_dq_oe", 32'(ctrl_dq_oe), 32'(0));
        chk("rstwr_dq_out", 32'(ctrl_dq_out), 32'(0));
        chk("rstwr_mem",   32'(sram_get(32'h20)), 32'(dflt(32'h20)));
        @(posedge clk);
        #1;
        issue(0, 32'h20, '0, '0);
        idle();
        drain();

        // Random traffic over a small address window.
        for (int n = 0; n < 80; n++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), 16'($urandom), 2'($urandom_range(0, 3)));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                idle();
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle();
        drain();
        for (int a = 0; a < 16; a++)
            chk("sweep_mem", 32'(sram_get(a)), 32'(ref_get(a)));

        chk("turnaround_violations", 32'(viol), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
